// File: rtl/radix4_digit_serializer.sv
// radix4_digit_serializer: Booth-recodes a parallel two's-complement operand into
// radix-4 signed digits {-2..2}, most-significant digit first, over a valid/enable handshake.
module radix4_digit_serializer #(
    parameter int no_of_digits = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2*no_of_digits-1:0] x,
    input  logic                      en,
    output logic                      ready,
    output logic [2:0]                q,
    output logic                      q_valid,
    output logic                      last
);
    localparam int W  = 2*no_of_digits + 1;
    localparam int CW = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(no_of_digits - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state, w_next;
    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic [2:0]    w_digit;

    // Top three bits of the window give -2*b2 + b1 + b0 in 3-bit two's complement.
    assign w_digit = (r_sr[W-1] ? 3'b110 : 3'b000) + {2'b00, r_sr[W-2]} + {2'b00, r_sr[W-3]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (start && ready) begin
                r_sr  <= {x, 1'b0};
                r_cnt <= CNT_MAX;
            end else if (q_valid && en) begin
                r_sr <= r_sr << 2;
                if (r_cnt != '0)
                    r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        q       = 3'b000;
        q_valid = 1'b0;
        last    = 1'b0;
        if (r_state == RUN) begin
            q       = w_digit;
            q_valid = 1'b1;
            last    = (r_cnt == '0);
            if (en && last)
                w_next = IDLE;
        end
        ready = (r_state == IDLE) || (last && en);
        if (start && ready)
            w_next = RUN;
    end
endmodule
